// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master's bridge-side command port among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort transfers that stay BUSY for TIMEOUT_CYCLES cycles.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ-1:0]            wr_rd_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          trans_o,
  output logic [ADDR_WIDTH-1:0]         maddr_o,
  output logic [DATA_WIDTH-1:0]         mwdata_o,
  output logic                          mwr_rd_o,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pready_i,
  input  logic [DATA_WIDTH-1:0]         mrdata_i,
  input  logic                          merr_i,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    xfer_done;
  logic                    load_cmd;
  logic                    set_abort;
  logic                    abort_q;
  logic                    tmo_hit;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ptr is always below NUM_REQ, so one conditional subtract wraps the scan.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Scanning from the far end lets the requester closest to ptr win.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[rr_index(ptr_q, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(ptr_q, i);
      end
    end
  end

  assign xfer_done = psel_i & penable_i & pready_i;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  // Counter sits at zero outside BUSY, so it restarts from zero on every grant.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tmo_cnt <= '0;
    end else if (state_q != BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_cmd  = 1'b0;
    set_abort = 1'b0;
    trans_o   = 1'b0;
    done_o    = '0;
    rdata_o   = '0;
    err_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load_cmd = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Dropping trans in the completion cycle sends the master back to its IDLE.
        trans_o = ~xfer_done;
        if (xfer_done) begin
          state_d = RESP;
        end else if (tmo_hit) begin
          set_abort = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        done_o  = gnt_o;
        err_o   = merr_i | abort_q;
        rdata_o = (mwr_rd_o | abort_q) ? '0 : mrdata_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ptr_q    <= '0;
      gnt_o    <= '0;
      maddr_o  <= '0;
      mwdata_o <= '0;
      mwr_rd_o <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= set_abort;
      if (load_cmd) begin
        maddr_o  <= addr_arr[pick_idx];
        mwdata_o <= wdata_arr[pick_idx];
        mwr_rd_o <= wr_rd_i[pick_idx];
        gnt_o    <= NUM_REQ'(1) << pick_idx;
        ptr_q    <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else if (state_q == RESP) begin
        gnt_o <= '0;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter with a behavioural APB master/slave and an expected-transfer queue.
// Build with APB_ARB_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_apb_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TMO     = 16;
  // Entry layout: {trans_cycles[7:0], addr, wdata, done_onehot, rdata, err}
  localparam int W       = 8 + AW + DW + NUM_REQ + DW + 1;

  // clock / reset
  logic pclk     = 1'b0;
  logic preset_n = 1'b1;
  always #5 pclk = ~pclk;

  logic [NUM_REQ-1:0]    req_i   = '0;
  logic [NUM_REQ*AW-1:0] addr_i  = '0;
  logic [NUM_REQ*DW-1:0] wdata_i = '0;
  logic [NUM_REQ-1:0]    wr_rd_i = '0;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    done_o;
  logic [DW-1:0]         rdata_o;
  logic                  err_o;
  logic                  trans_o;
  logic [AW-1:0]         maddr_o;
  logic [DW-1:0]         mwdata_o;
  logic                  mwr_rd_o;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pready_i;
  logic [DW-1:0]         mrdata_i;
  logic                  merr_i;
  logic [1:0]            dbg_state;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  int   cfg_wait = 0;
  logic cfg_err  = 1'b0;

  apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wr_rd_i(wr_rd_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .trans_o(trans_o), .maddr_o(maddr_o), .mwdata_o(mwdata_o), .mwr_rd_o(mwr_rd_o),
    .psel_i(psel_i), .penable_i(penable_i), .pready_i(pready_i), .mrdata_i(mrdata_i),
    .merr_i(merr_i), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | (a >> 4);
  endfunction

  // APB master + slave model: IDLE -> SETUP -> ACCESS, cfg_wait low-pready cycles in ACCESS.
  localparam logic [1:0] M_IDLE = 2'd0, M_SETUP = 2'd1, M_ACCESS = 2'd2;
  logic [1:0]    m_state;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  int            wait_cnt;

  assign psel_i    = (m_state != M_IDLE);
  assign penable_i = (m_state == M_ACCESS);
  assign pready_i  = (m_state == M_ACCESS) && (wait_cnt >= cfg_wait);

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_state  <= M_IDLE;
      m_addr   <= '0;
      m_wr     <= 1'b0;
      wait_cnt <= 0;
      mrdata_i <= '0;
      merr_i   <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (trans_o) begin
          m_state <= M_SETUP;
          m_addr  <= maddr_o;
          m_wr    <= mwr_rd_o;
        end
        M_SETUP: begin
          m_state  <= M_ACCESS;
          wait_cnt <= 0;
        end
        M_ACCESS: begin
          if (pready_i) begin
            m_state  <= M_IDLE;
            merr_i   <= cfg_err;
            // a write leaves stale data on the master's rdata; the arbiter must mask it
            mrdata_i <= cfg_err ? '0 : slave_data(m_addr);
          end else if (!trans_o) begin
            m_state <= M_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check(tag, 128'({gnt_o, done_o, rdata_o, err_o, trans_o, maddr_o, mwdata_o, mwr_rd_o, dbg_state}),
          128'(0));
  endtask

  // driver tasks
  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_i[k*AW +: AW]  = a;
    wdata_i[k*DW +: DW] = d;
    wr_rd_i[k]          = wr;
  endtask

  task automatic expect_xfer(input int k, input int tr, input logic err, input logic [DW-1:0] rdata);
    logic [W-1:0] e;
    e = {8'(tr), addr_i[k*AW +: AW], wdata_i[k*DW +: DW], NUM_REQ'(1) << k, rdata, err};
    exp_q.push_back(e);
  endtask

  task automatic wait_dones(input int n, input logic [NUM_REQ-1:0] drop_mask, input int budget);
    int target;
    int cyc;
    target = done_cnt + n;
    cyc    = 0;
    while (done_cnt < target && cyc < budget) begin
      @(negedge pclk);
      #1;
      cyc++;
    end
    check("done_within_budget", 128'(done_cnt >= target), 128'(1));
    req_i = req_i & ~drop_mask;
  endtask

  task automatic wait_gnt(input int k, input int budget);
    int cyc;
    cyc = 0;
    do begin
      @(negedge pclk);
      #1;
      cyc++;
    end while (!gnt_o[k] && cyc < budget);
    check("gnt_seen", 128'(gnt_o[k]), 128'(1));
  endtask

  task automatic wait_trans(input int budget);
    int cyc;
    cyc = 0;
    do begin
      @(negedge pclk);
      #1;
      cyc++;
    end while (!trans_o && cyc < budget);
    check("trans_seen", 128'(trans_o), 128'(1));
  endtask

  // scoreboard / monitor, sampled on the falling edge
  logic          g_active   = 1'b0;
  logic          g_unstable = 1'b0;
  int            g_trans    = 0;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [W-1:0]  e_pop;

  always @(negedge pclk) begin
    if (!preset_n) begin
      g_active = 1'b0;
    end else begin
      if (gnt_o != '0) begin
        check("gnt_onehot", 128'($onehot(gnt_o)), 128'(1));
        if (!g_active) begin
          g_active   = 1'b1;
          g_addr     = maddr_o;
          g_wdata    = mwdata_o;
          g_unstable = 1'b0;
          g_trans    = 0;
        end else if (maddr_o !== g_addr || mwdata_o !== g_wdata) begin
          g_unstable = 1'b1;
        end
        if (trans_o) g_trans++;
      end else if (trans_o) begin
        check("trans_without_gnt", 128'(trans_o), 128'(0));
      end
      if (done_o != '0) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 128'(done_o), 128'(0));
        end else begin
          e_pop = exp_q.pop_front();
          check("done_req",     128'(done_o),   128'(e_pop[36:33]));
          check("rdata",        128'(rdata_o),  128'(e_pop[32:1]));
          check("err",          128'(err_o),    128'(e_pop[0]));
          check("maddr",        128'(maddr_o),  128'(e_pop[100:69]));
          check("mwdata",       128'(mwdata_o), 128'(e_pop[68:37]));
          check("trans_cycles", 128'(g_trans),  128'(e_pop[108:101]));
        end
        check("done_eq_gnt",   128'(done_o),     128'(gnt_o));
        check("trans_in_resp", 128'(trans_o),    128'(0));
        check("cmd_stable",    128'(g_unstable), 128'(0));
        g_active = 1'b0;
      end
    end
  end

  initial begin
    #1 preset_n = 1'b0;
    #1 outputs_zero("reset_outputs");
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;

    // round robin from ptr=0 with all four requesting
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, AW'((k + 1) * 16), DW'(32'h1111_0000 + k));
    for (int n = 0; n < 5; n++) expect_xfer(n % NUM_REQ, 2, 1'b0, slave_data(AW'(((n % NUM_REQ) + 1) * 16)));
    req_i = '1;
    wait_dones(5, '1, 200);

    // single read, zero wait states
    set_req(0, 1'b0, 32'h10, 32'h0);
    expect_xfer(0, 2, 1'b0, 32'hA5A5_0001);
    req_i = 4'b0001;
    wait_dones(1, 4'b0001, 50);

    // write with three wait states
    set_req(2, 1'b1, 32'h30, 32'hDEAD_BEEF);
    cfg_wait = 3;
    expect_xfer(2, 5, 1'b0, 32'h0);
    req_i = 4'b0100;
    wait_dones(1, 4'b0100, 50);
    cfg_wait = 0;

    // slave error, then two normal grants
    set_req(3, 1'b0, 32'h40, 32'h0);
    cfg_err = 1'b1;
    expect_xfer(3, 2, 1'b1, 32'h0);
    req_i = 4'b1000;
    wait_dones(1, 4'b1000, 50);
    cfg_err = 1'b0;
    set_req(1, 1'b0, 32'h20, 32'h0);
    expect_xfer(0, 2, 1'b0, 32'hA5A5_0001);
    expect_xfer(1, 2, 1'b0, 32'hA5A5_0002);
    req_i = 4'b0011;
    wait_dones(2, 4'b0011, 100);

    // request withdrawn right after grant still completes
    expect_xfer(1, 2, 1'b0, 32'hA5A5_0002);
    req_i = 4'b0010;
    wait_gnt(1, 20);
    req_i = '0;
    wait_dones(1, '0, 50);

    // asynchronous reset during BUSY; pointer was 2 before, must restart from 0
    set_req(2, 1'b0, 32'h30, 32'h0);
    req_i = 4'b0010;
    wait_trans(20);
    #2 preset_n = 1'b0;
    #1 outputs_zero("async_reset_outputs");
    req_i = 4'b0101;
    repeat (2) @(negedge pclk);
    expect_xfer(0, 2, 1'b0, 32'hA5A5_0001);
    expect_xfer(2, 2, 1'b0, 32'hA5A5_0003);
    preset_n = 1'b1;
    wait_dones(2, 4'b0101, 100);

`ifdef APB_ARB_TIMEOUT_EN
    // pready never rises: abort after TMO busy cycles
    cfg_wait = 100000;
    expect_xfer(0, TMO, 1'b1, 32'h0);
    req_i = 4'b0001;
    wait_dones(1, 4'b0001, 60);
    cfg_wait = 0;
`endif

    repeat (4) @(negedge pclk);
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
